ic_ram_arbiter: RTL and testbench

Two-master to one-slave arbiter for the SoC CPU memory bus (req/gnt request channel, recv/ack response channel). It lets the CPU instruction port (m0) and data port (m1) share one RAM bus bridge, so code and data can live in a single BRAM. It sits between the interconnect and an ic_cpu_bus_bram_bridge instance. It tracks outstanding transactions in order, so each response is returned to the master that issued the request.

---
 rtl/ic_ram_arbiter_if.sv | 24 ++
 rtl/ic_ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ic_ram_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ic_ram_arbiter_if.sv
// CPU memory bus bundle: req/gnt request channel plus recv/ack response channel.
// The "master" view drives requests and accepts responses, and the "slave" view is the opposite side.
interface ic_ram_arbiter_if;
  logic        req;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        gnt;
  logic        recv;
  logic        ack;
  logic        error;
  logic [31:0] rdata;

  modport master (
    output req, wen, strb, wdata, addr, ack,
    input  gnt, recv, error, rdata
  );

  modport slave (
    input  req, wen, strb, wdata, addr, ack,
    output gnt, recv, error, rdata
  );
endinterface

// File: rtl/ic_ram_arbiter.sv
// Two-master (m0 = instruction port, m1 = data port) to one-slave bus arbiter.
// The request path is a zero-latency mux. Arbitration gives priority to m1, with a starvation escape for m0.
// An order FIFO of master IDs routes each in-order response back to the master that issued the request.
module ic_ram_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  ic_ram_arbiter_if.slave   m0,
  ic_ram_arbiter_if.slave   m1,
  ic_ram_arbiter_if.master  s,
  output logic              resp_orphan
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(OUTSTANDING - 1);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;      // 0 = m0, 1 = m1
  logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               id_mem [OUTSTANDING];

  logic sel;            // selected master this cycle
  logic starve_force;
  logic fifo_full;
  logic fifo_empty;
  logic head;
  logic push;
  logic pop;

  assign fifo_full  = (count_q == FULL_C);
  assign fifo_empty = (count_q == '0);
  assign head       = id_mem[rd_ptr_q];
  assign push       = s.req && s.gnt;
  assign pop        = s.recv && s.ack && !fifo_empty;

  // Arbiter state and owner register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next state: lock the winner while the slave stalls, and release it once the request is accepted
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (s.req && !s.gnt) begin
          state_d = ST_HOLD;
          owner_d = sel;
        end
      end
      ST_HOLD: begin
        if (push) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request-side outputs: winner selection, payload mux, and grants blocked while the FIFO is full
  always_comb begin
    starve_force = (STARVE_LIMIT != 0) && (starve_cnt_q == LIMIT_C) && m0.req;
    if (state_q == ST_HOLD) sel = owner_q;
    else                    sel = m1.req && !starve_force;
    s.req   = (sel ? m1.req : m0.req) && !fifo_full;
    s.wen   = sel ? m1.wen   : m0.wen;
    s.strb  = sel ? m1.strb  : m0.strb;
    s.wdata = sel ? m1.wdata : m0.wdata;
    s.addr  = sel ? m1.addr  : m0.addr;
    m0.gnt  = s.req && s.gnt && !sel;
    m1.gnt  = s.req && s.gnt &&  sel;
  end

  // Response-side outputs: route to the head master, and discard a response when nothing is outstanding
  always_comb begin
    m0.recv     = s.recv && !fifo_empty && !head;
    m1.recv     = s.recv && !fifo_empty &&  head;
    m0.rdata    = s.rdata;
    m1.rdata    = s.rdata;
    m0.error    = s.error;
    m1.error    = s.error;
    s.ack       = fifo_empty ? s.recv : (head ? m1.ack : m0.ack);
    resp_orphan = s.recv && fifo_empty;
  end

  // Order FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Order FIFO state registers
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Order FIFO storage holds the ID of each accepted request. Contents need no reset because occupancy is tracked separately.
  always_ff @(posedge g_clk) begin
    if (push) id_mem[wr_ptr_q] <= sel;
  end

  // Starvation counter: count the cycles m0 waits, saturating at the limit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m0.req || m0.gnt)            starve_cnt_d = '0;
    else if (starve_cnt_q != LIMIT_C) starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Starvation counter register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) starve_cnt_q <= '0;
    else           starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: tb/tb_ic_ram_arbiter.sv
// Randomized bench for ic_ram_arbiter. It checks the arbiter against a transaction-level model
// made of a queue of outstanding master IDs, a wait counter for m0, and an optional locked owner.
module tb_ic_ram_arbiter;
  localparam int OUTST = 2;
  localparam int LIMIT = 4;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic resp_orphan;

  ic_ram_arbiter_if m0_bus();
  ic_ram_arbiter_if m1_bus();
  ic_ram_arbiter_if s_bus();

  ic_ram_arbiter #(.OUTSTANDING(OUTST), .STARVE_LIMIT(LIMIT)) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .resp_orphan (resp_orphan)
  );

  always #5 g_clk = ~g_clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state
  int          ord_q[$];
  int          waited;
  int          hold_owner;
  bit          act[2];
  logic        wen_v[2];
  logic [3:0]  strb_v[2];
  logic [31:0] addr_v[2];
  logic [31:0] wdata_v[2];
  bit          ack_v[2];
  int p_req, p_gnt, p_recv, p_ack;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive_masters();
    m0_bus.req = act[0]; m0_bus.wen = wen_v[0]; m0_bus.strb = strb_v[0];
    m0_bus.wdata = wdata_v[0]; m0_bus.addr = addr_v[0]; m0_bus.ack = ack_v[0];
    m1_bus.req = act[1]; m1_bus.wen = wen_v[1]; m1_bus.strb = strb_v[1];
    m1_bus.wdata = wdata_v[1]; m1_bus.addr = addr_v[1]; m1_bus.ack = ack_v[1];
  endtask

  task automatic run_cycle(input bit force_recv);
    bit full, empty, forced, e_sreq, push, pop, e_sack, e_orph;
    bit e_gnt[2];
    bit e_recv[2];
    int win, head;
    @(negedge g_clk);
    for (int m = 0; m < 2; m++) begin
      if (!act[m] && ($urandom_range(99) < p_req)) begin
        act[m] = 1'b1;
        wen_v[m] = 1'($urandom_range(1));
        strb_v[m] = 4'($urandom);
        addr_v[m] = $urandom;
        wdata_v[m] = $urandom;
      end
      ack_v[m] = ($urandom_range(99) < p_ack);
    end
    drive_masters();
    s_bus.gnt = ($urandom_range(99) < p_gnt);
    s_bus.recv = force_recv || ($urandom_range(99) < p_recv);
    s_bus.rdata = $urandom;
    s_bus.error = 1'($urandom_range(1));
    #1;
    full = (ord_q.size() == OUTST);
    empty = (ord_q.size() == 0);
    head = empty ? 0 : ord_q[0];
    forced = (LIMIT != 0) && (waited == LIMIT);
    if (hold_owner >= 0) win = hold_owner;
    else if (act[1] && !(forced && act[0])) win = 1;
    else win = 0;
    e_sreq = !full && act[win];
    for (int m = 0; m < 2; m++) begin
      e_gnt[m] = e_sreq && s_bus.gnt && (win == m);
      e_recv[m] = s_bus.recv && !empty && (head == m);
    end
    e_sack = empty ? s_bus.recv : ack_v[head];
    e_orph = s_bus.recv && empty;

    check_eq("s_req", 32'(s_bus.req), 32'(e_sreq));
    check_eq("m0_gnt", 32'(m0_bus.gnt), 32'(e_gnt[0]));
    check_eq("m1_gnt", 32'(m1_bus.gnt), 32'(e_gnt[1]));
    check_eq("m0_recv", 32'(m0_bus.recv), 32'(e_recv[0]));
    check_eq("m1_recv", 32'(m1_bus.recv), 32'(e_recv[1]));
    check_eq("s_ack", 32'(s_bus.ack), 32'(e_sack));
    check_eq("resp_orphan", 32'(resp_orphan), 32'(e_orph));
    if (e_sreq) begin
      check_eq("s_addr", s_bus.addr, addr_v[win]);
      check_eq("s_wdata", s_bus.wdata, wdata_v[win]);
      check_eq("s_ctl", {27'd0, s_bus.wen, s_bus.strb}, {27'd0, wen_v[win], strb_v[win]});
    end
    if (e_recv[0]) check_eq("m0_rdata", m0_bus.rdata, s_bus.rdata);
    if (e_recv[1]) check_eq("m1_rdata", m1_bus.rdata, s_bus.rdata);

    pop = s_bus.recv && e_sack && !empty;
    push = e_sreq && s_bus.gnt;
    if (!act[0] || e_gnt[0]) waited = 0;
    else if (waited < LIMIT) waited++;
    if (pop) begin
      $display("resp  m%0d rdata=%h err=%0b t=%0t", head, s_bus.rdata, s_bus.error, $time);
      void'(ord_q.pop_front());
    end else if (e_orph && s_bus.ack) begin
      $display("orphan response discarded t=%0t", $time);
    end
    if (push) begin
      $display("req   m%0d addr=%h wen=%0b t=%0t", win, addr_v[win], wen_v[win], $time);
      ord_q.push_back(win);
      act[win] = 1'b0;
      hold_owner = -1;
    end else if (e_sreq && !s_bus.gnt && hold_owner < 0) begin
      hold_owner = win;
    end
  endtask

  task automatic do_reset();
    @(negedge g_clk);
    g_resetn = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    drive_masters();
    s_bus.recv = 1'b0;
    s_bus.gnt = 1'b1;
    #1;
    check_eq("rst_s_req", 32'(s_bus.req), 32'd0);
    check_eq("rst_s_ack", 32'(s_bus.ack), 32'd0);
    check_eq("rst_orphan", 32'(resp_orphan), 32'd0);
    check_eq("rst_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 32'd0);
    s_bus.recv = 1'b1;
    #1;
    check_eq("rst_orph_ack", 32'(s_bus.ack), 32'd1);
    check_eq("rst_orph_pulse", 32'(resp_orphan), 32'd1);
    check_eq("rst_orph_recv", {30'd0, m1_bus.recv, m0_bus.recv}, 32'd0);
    ord_q.delete();
    waited = 0;
    hold_owner = -1;
    @(negedge g_clk);
    s_bus.recv = 1'b0;
    g_resetn = 1'b1;
    $display("reset released t=%0t", $time);
  endtask

  task automatic run_phase(input int req_p, input int gnt_p, input int recv_p,
                           input int ack_p, input int cycles);
    p_req = req_p; p_gnt = gnt_p; p_recv = recv_p; p_ack = ack_p;
    for (int i = 0; i < cycles; i++) run_cycle(1'b0);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; wen_v[m] = 1'b0; strb_v[m] = 4'h0;
      addr_v[m] = 32'h0; wdata_v[m] = 32'h0; ack_v[m] = 1'b0;
    end
    drive_masters();
    s_bus.gnt = 1'b0; s_bus.recv = 1'b0; s_bus.rdata = 32'h0; s_bus.error = 1'b0;
    waited = 0;
    hold_owner = -1;
    do_reset();

    run_phase(100, 100, 100, 100, 300);  // both masters busy, slave always ready
    run_phase(90, 30, 50, 80, 400);      // slave stalls, exercising owner hold
    run_phase(90, 90, 10, 50, 400);      // slow responses keep the FIFO full
    // reset while transactions are outstanding, then a stale response arrives
    while (ord_q.size() != OUTST) run_cycle(1'b0);
    do_reset();
    p_req = 0;
    run_cycle(1'b1);
    run_phase(60, 70, 60, 60, 400);      // mixed traffic with occasional orphans
    run_phase(100, 100, 30, 100, 300);   // m0 starvation escape under m1 pressure

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog bound on the run
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
